// File: rtl/cxl_arb_pkg.sv
// Shared widths and controller state encoding for the get_Cxl request arbiter.
package cxl_arb_pkg;

    localparam int CLIENT_ID_W = 5;
    localparam int AMOUNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        any       = |req_valid;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
                grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/cxl_get_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto the single get_Cxl port
// and returns a done or error pulse to the requester that was granted.
module cxl_get_arbiter
    import cxl_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*CLIENT_ID_W-1:0] req_client_id,
    input  logic [NUM_REQ*AMOUNT_W-1:0]   req_amount,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic [NUM_REQ-1:0]            rsp_error,
    output logic                          cxl_valid,
    output logic [CLIENT_ID_W-1:0]        cxl_client_id,
    output logic [AMOUNT_W-1:0]           cxl_amount,
    input  logic                          cxl_ack,
    output logic                          busy,
    output logic [15:0]                   done_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [TMR_W-1:0]     timer;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [CLIENT_ID_W-1:0] sel_id;
    logic [AMOUNT_W-1:0]  sel_amount;
    logic [IDX_W-1:0]     next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign sel_id     = req_client_id[int'(pick_idx) * CLIENT_ID_W +: CLIENT_ID_W];
    assign sel_amount = req_amount[int'(pick_idx) * AMOUNT_W +: AMOUNT_W];
    assign next_ptr   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Handshake: a requester holds req_valid until it sees its req_ready bit (a one-cycle
    // accept pulse, after which payload changes are ignored); toward get_Cxl, cxl_valid
    // and its payload stay stable until cxl_ack is sampled high at a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_idx       <= '0;
            gnt_oh        <= '0;
            timer         <= '0;
            req_ready     <= '0;
            rsp_done      <= '0;
            rsp_error     <= '0;
            cxl_valid     <= 1'b0;
            cxl_client_id <= '0;
            cxl_amount    <= '0;
            busy          <= 1'b0;
            done_count    <= '0;
        end else begin
            req_ready <= '0;
            rsp_done  <= '0;
            rsp_error <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_oh        <= pick_oh;
                        gnt_idx       <= pick_idx;
                        req_ready     <= pick_oh;
                        cxl_client_id <= sel_id;
                        cxl_amount    <= sel_amount;
                        timer         <= '0;
                        busy          <= 1'b1;
                        // A zero-length request never reaches get_Cxl.
                        if (sel_amount == '0) begin
                            state     <= ERR;
                            rsp_error <= pick_oh;
                        end else begin
                            state     <= ISSUE;
                            cxl_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cxl_ack) begin
                        state     <= DONE;
                        cxl_valid <= 1'b0;
                        rsp_done  <= gnt_oh;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state     <= ERR;
                        cxl_valid <= 1'b0;
                        rsp_error <= gnt_oh;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    done_count <= done_count + 16'd1;
                    rr_ptr     <= next_ptr;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                ERR: begin
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
